// File: rtl/mul4b_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier driving one shared 4-bit ripple adder.
// Each ADD cycle adds the multiplicand (or zero) into the high nibble, then shifts {co, acc, q} right.

module sum4b (
    input  logic [3:0] xi,
    input  logic [3:0] yi,
    output logic [3:0] zi,
    output logic       co
);

    // One full-adder cell, returned as {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    logic [1:0] fa0_s;
    logic [1:0] fa1_s;
    logic [1:0] fa2_s;
    logic [1:0] fa3_s;

    assign fa0_s = full_add(xi[0], yi[0], 1'b0);
    assign fa1_s = full_add(xi[1], yi[1], fa0_s[1]);
    assign fa2_s = full_add(xi[2], yi[2], fa1_s[1]);
    assign fa3_s = full_add(xi[3], yi[3], fa2_s[1]);

    assign zi = {fa3_s[0], fa2_s[0], fa1_s[0], fa0_s[0]};
    assign co = fa3_s[1];

endmodule

module mul4b_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [1:0]         cnt_r;
    logic [1:0]         cnt_s;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mcand_s;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   acc_s;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   q_s;
    logic [2*WIDTH-1:0] p_r;
    logic [2*WIDTH-1:0] p_s;
    logic               busy_r;
    logic               busy_s;
    logic               done_r;
    logic               done_s;

    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH-1:0]   sum_s;
    logic               carry_s;

    assign addend_s = q_r[0] ? mcand_r : 4'h0;

    sum4b u_add (
        .xi (acc_r),
        .yi (addend_s),
        .zi (sum_s),
        .co (carry_s)
    );

    // State register; reset discards any multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath next values; everything holds unless the state says otherwise.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        mcand_s = mcand_r;
        acc_s   = acc_r;
        q_s     = q_r;
        p_s     = p_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    mcand_s = a;
                    q_s     = b;
                    acc_s   = 4'h0;
                    cnt_s   = 2'd0;
                    state_s = ADD;
                end else begin
                    state_s = IDLE;
                end
            end
            ADD: begin
                // The adder carry becomes the new MSB, so the product never overflows.
                acc_s = {carry_s, sum_s[WIDTH-1:1]};
                q_s   = {sum_s[0], q_r[WIDTH-1:1]};
                cnt_s = cnt_r + 2'd1;
                if (cnt_r == 2'd3) begin
                    p_s     = {acc_s, q_s};
                    state_s = DONE;
                end else begin
                    state_s = ADD;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
        done_s = (state_s == DONE);
    end

    // Datapath and registered status outputs, aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= 2'd0;
            mcand_r <= 4'h0;
            acc_r   <= 4'h0;
            q_r     <= 4'h0;
            p_r     <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_s;
            mcand_r <= mcand_s;
            acc_r   <= acc_s;
            q_r     <= q_s;
            p_r     <= p_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign p    = p_r;

endmodule
